// File: rtl/data_mem_ctrl.sv
// Data-memory controller: CPU MEM-stage port to a ready/rvalid bus, with a one-entry
// posted write buffer that drains in the background and forwards to matching loads.
module data_mem_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst_n,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_raddr,
    input  logic                       cpu_data_mem_read,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_waddr,
    input  logic [DATA_WIDTH-1:0]      cpu_data_mem_wdata,
    input  logic                       cpu_data_mem_write,
    output logic [DATA_WIDTH-1:0]      data_mem_rdata,
    output logic                       data_mem_hazard,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic                       mem_ready,
    input  logic                       mem_rvalid,
    input  logic [DATA_WIDTH-1:0]      mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        RD_DONE = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic                       wb_valid_q, wb_valid_d;
    logic [DATA_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_WIDTH-1:0]      wb_data_q, wb_data_d;
    logic [DATA_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0]      rd_q, rd_d;

    logic wr_req;
    logic rd_req;
    logic wb_hit;
    logic drain_hs;

    // A simultaneous read and write is treated as a write only.
    assign wr_req   = cpu_data_mem_write;
    assign rd_req   = cpu_data_mem_read & ~cpu_data_mem_write;
    assign wb_hit   = wb_valid_q & (wb_addr_q == cpu_data_mem_raddr);
    assign drain_hs = (state_q == IDLE) & wb_valid_q & mem_ready;

    // Stall decision uses only state, buffer and CPU inputs, never the bus handshake.
    always_comb begin
        data_mem_hazard = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    data_mem_hazard = wb_valid_q;
                end else if (rd_req) begin
                    data_mem_hazard = ~wb_hit;
                end
            end
            RD_REQ, RD_WAIT: data_mem_hazard = 1'b1;
            default:         data_mem_hazard = 1'b0;
        endcase
    end

    always_comb begin
        data_mem_rdata = rd_q;
        if ((state_q == IDLE) && rd_req && wb_hit) begin
            data_mem_rdata = wb_data_q;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = wb_addr_q;
        mem_wdata = wb_data_q;
        case (state_q)
            IDLE: begin
                mem_req = wb_valid_q;
                mem_we  = wb_valid_q;
            end
            RD_REQ: begin
                mem_req  = 1'b1;
                mem_we   = 1'b0;
                mem_addr = rd_addr_q;
            end
            default: begin
                mem_req = 1'b0;
                mem_we  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        rd_addr_d  = rd_addr_q;
        rd_d       = rd_q;
        case (state_q)
            IDLE: begin
                if (drain_hs) begin
                    wb_valid_d = 1'b0;
                end
                if (wr_req) begin
                    if (!wb_valid_q) begin
                        wb_valid_d = 1'b1;
                        wb_addr_d  = cpu_data_mem_waddr;
                        wb_data_d  = cpu_data_mem_wdata;
                    end
                end else if (rd_req && !wb_hit && (!wb_valid_q || drain_hs)) begin
                    // A miss may launch in the same cycle the drain completes.
                    state_d   = RD_REQ;
                    rd_addr_d = cpu_data_mem_raddr;
                end
            end
            RD_REQ: begin
                if (mem_ready) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    rd_d    = mem_rdata;
                    state_d = RD_DONE;
                end
            end
            default: begin
                // The completed read is still presented here; do not reissue it.
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            rd_addr_q  <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_q       <= rd_d;
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory controller between the CPU's MEM-stage data port and a variable-latency backing memory with a request/ready/rvalid handshake. It turns the CPU's single-cycle read/write port into bus transactions, holds one posted write in a write buffer, and forwards buffered write data to matching reads. It drives `data_mem_hazard` to freeze the pipeline while a transaction is outstanding. Word accesses only.

## Interface
- `DATA_WIDTH`, 32, data word width
- `DATA_ADDR_WIDTH`, 32, byte address width; addresses are word aligned, compared on all bits

- `cpu_clk`  in  1  clock, rising edge
- `cpu_rst_n`  in  1  reset, synchronous, active-low
- `cpu_data_mem_raddr`  in  DATA_ADDR_WIDTH  CPU read address
- `cpu_data_mem_read`  in  1  CPU read request (load in MEM stage)
- `cpu_data_mem_waddr`  in  DATA_ADDR_WIDTH  CPU write address
- `cpu_data_mem_wdata`  in  DATA_WIDTH  CPU write data
- `cpu_data_mem_write`  in  1  CPU write request (store in MEM stage)
- `data_mem_rdata`  out  DATA_WIDTH  read data to CPU; valid in any cycle where a read is presented and `data_mem_hazard`=0
- `data_mem_hazard`  out  1  stall request to CPU (combinational)
- `mem_req`  out  1  bus request valid
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`
- `mem_addr`  out  DATA_ADDR_WIDTH  bus address
- `mem_wdata`  out  DATA_WIDTH  bus write data
- `mem_ready`  in  1  bus accepts the request this cycle (`mem_req & mem_ready` = handshake)
- `mem_rvalid`  in  1  read data returned; never in the same cycle as its read handshake
- `mem_rdata`  in  DATA_WIDTH  bus read data, valid with `mem_rvalid`

## Operation
- Write buffer: one entry {`wb_valid`, `wb_addr`, `wb_data`}.
- FSM states: IDLE, RD_REQ, RD_WAIT, RD_DONE.
- IDLE:
  - `mem_req`=`wb_valid`, `mem_we`=1, `mem_addr`/`mem_wdata`=buffer contents (background drain).
  - On the drain handshake, `wb_valid` clears at the clock edge.
- Write in IDLE:
  - If `wb_valid`=0: capture into the buffer. `hazard`=0, so the store retires with zero stall.
  - If `wb_valid`=1: `hazard`=1 until the cycle after the buffer empties. The write is accepted in the first IDLE cycle with `wb_valid`=0.
- Read in IDLE, buffer hit (`wb_valid` and `wb_addr`==`raddr`):
  - `data_mem_rdata`=`wb_data`, `hazard`=0, no bus activity beyond any ongoing drain.
- Read in IDLE, miss:
  - `hazard`=1.
  - If `wb_valid`=1, stay in IDLE until the drain completes.
  - If `wb_valid`=0, go to RD_REQ.
- RD_REQ:
  - `mem_req`=1, `mem_we`=0, `mem_addr`=`raddr`, `hazard`=1.
  - Go to RD_WAIT on `mem_ready`.
- RD_WAIT:
  - `hazard`=1.
  - On `mem_rvalid`: capture `mem_rdata` into `rd_q` and go to RD_DONE.
- RD_DONE:
  - `hazard`=0, `data_mem_rdata`=`rd_q`, no bus request.
  - Always return to IDLE. The same read is still on the inputs this cycle and must not be reissued.
- `data_mem_rdata` outside a hit or RD_DONE = `rd_q`.
- Read and write asserted together is illegal. The block treats it as a write only.
- The CPU holds all request inputs stable while `hazard`=1. No new request arrives in RD_REQ or RD_WAIT.

## Timing
- Reset (`cpu_rst_n`=0 at an edge): state=IDLE, `wb_valid`=0, `wb_addr`/`wb_data`=0, `rd_q`=0.
  - Resulting outputs: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `data_mem_hazard`=0 (if no request presented), `data_mem_rdata`=0.
- Reset mid-transaction: the FSM aborts to IDLE and the buffered write is discarded. A late `mem_rvalid` arriving in IDLE is ignored.
- Read miss, empty buffer, `mem_ready` immediate, `mem_rvalid` N≥1 cycles after the handshake: `hazard` high for 2+N cycles, low in the RD_DONE cycle.
  - Minimum is 3 stall cycles.
- Store followed by a load to another address:
  - The store retires in cycle 0 and the drain request appears in cycle 1.
  - If the load is presented in cycle 1 and `mem_ready`=1 there, RD_REQ starts in cycle 2.
- `mem_req`/`mem_addr`/`mem_we`/`mem_wdata` stay stable while `mem_req`=1 and `mem_ready`=0.
- No combinational path from `mem_ready`/`mem_rvalid` to `data_mem_hazard`. Hazard depends only on state, buffer and CPU inputs.

## Test plan
- Reset, then idle inputs:
  - Required: all outputs 0 and no `mem_req` for 10 cycles.
- Load miss, buffer empty; `raddr`=0x100; `mem_ready`=1 at once; `mem_rvalid` 2 cycles later with 0xDEADBEEF:
  - Required: `hazard`=1 for 4 cycles, then `rdata`=0xDEADBEEF with `hazard`=0 for exactly one cycle.
  - Required: exactly one read handshake.
- Store 0xCAFEF00D to 0x200, then load 0x200 the next cycle with `mem_ready`=0:
  - Required: zero-stall store.
  - Required: the load hits with `rdata`=0xCAFEF00D and `hazard`=0.
- Store to 0x300, then store to 0x304 with `mem_ready` held 0 for 3 cycles:
  - Required: the second store stalls until the drain handshake plus one cycle.
  - Required: bus sees 0x300, then 0x304, in order.
- Store to 0x400, then load 0x500 (miss):
  - Required: the write handshake precedes the read request.
  - Required: the load returns bus data, not the buffered 0x400 data.
- Assert reset while in RD_WAIT; fire `mem_rvalid` after reset:
  - Required: state IDLE, `hazard`=0, `rd_q`=0, `rvalid` ignored.
